// File: rtl/cmul_arbiter.sv
// cmul_arbiter: two-requester round-robin front end for a shared 2-stage complex multiplier.
// Define CMUL_ARB_ROUND_EN for round-half-up scaling; plain truncation otherwise.
module cmul_arbiter #(
  parameter int WIDTH = 16,
  parameter int TAGW  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic signed [WIDTH-1:0] req0_ar,
  input  logic signed [WIDTH-1:0] req0_ai,
  input  logic signed [WIDTH-1:0] req0_br,
  input  logic signed [WIDTH-1:0] req0_bi,
  input  logic signed [WIDTH-1:0] req1_ar,
  input  logic signed [WIDTH-1:0] req1_ai,
  input  logic signed [WIDTH-1:0] req1_br,
  input  logic signed [WIDTH-1:0] req1_bi,
  input  logic [TAGW-1:0]         req0_tag,
  input  logic [TAGW-1:0]         req1_tag,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    res_id,
  output logic [TAGW-1:0]         res_tag,
  output logic signed [WIDTH-1:0] res_mr,
  output logic signed [WIDTH-1:0] res_mi
);
  localparam int P = 2 * WIDTH;
`ifdef CMUL_ARB_ROUND_EN
  localparam logic signed [P-1:0] rnd = P'(1) <<< (WIDTH - 2);
`else
  localparam logic signed [P-1:0] rnd = '0;
`endif
  logic                    s1_valid, s1_id, s2_valid, s2_id, last;
  logic                    adv1, adv2, g, acc;
  logic [TAGW-1:0]         s1_tag, s2_tag;
  logic signed [WIDTH-1:0] s1_ar, s1_ai, s1_br, s1_bi, s2_mr, s2_mi, mr, mi;
  logic signed [P-1:0]     arbr, arbi, aibr, aibi;

  function automatic logic signed [WIDTH-1:0] tr(input logic signed [P-1:0] p);
    return WIDTH'((p + rnd) >>> (WIDTH - 1));
  endfunction

  always_comb begin
    adv2      = !s2_valid | res_ready;
    adv1      = !s1_valid | adv2;
    g         = &req_valid ? !last : req_valid[1];
    acc       = reset & |req_valid & adv1;
    req_ready = acc ? (g ? 2'b10 : 2'b01) : 2'b00;
    arbr      = P'(s1_ar) * P'(s1_br);
    arbi      = P'(s1_ar) * P'(s1_bi);
    aibr      = P'(s1_ai) * P'(s1_br);
    aibi      = P'(s1_ai) * P'(s1_bi);
    mr        = tr(arbr) - tr(aibi);
    mi        = tr(arbi) + tr(aibr);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_tag   <= '0;
      s1_ar    <= '0;
      s1_ai    <= '0;
      s1_br    <= '0;
      s1_bi    <= '0;
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
      s2_tag   <= '0;
      s2_mr    <= '0;
      s2_mi    <= '0;
      last     <= 1'b1;
    end else begin
      if (adv1) begin
        s1_valid <= acc;
        if (acc) begin
          s1_id  <= g;
          s1_tag <= g ? req1_tag : req0_tag;
          s1_ar  <= g ? req1_ar : req0_ar;
          s1_ai  <= g ? req1_ai : req0_ai;
          s1_br  <= g ? req1_br : req0_br;
          s1_bi  <= g ? req1_bi : req0_bi;
          last   <= g;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_id  <= s1_id;
          s2_tag <= s1_tag;
          s2_mr  <= mr;
          s2_mi  <= mi;
        end
      end
    end
  end

  assign res_valid = s2_valid;
  assign res_id    = s2_id;
  assign res_tag   = s2_tag;
  assign res_mr    = s2_mr;
  assign res_mi    = s2_mi;
endmodule

// File: tb/tb_cmul_arbiter.sv
// tb_cmul_arbiter: directed and randomized checks of cmul_arbiter against an occupancy-level model.
module tb_cmul_arbiter;
  logic        clk = 0, rst_n = 0, res_ready = 1;
  logic [1:0]  req_valid = 0, req_ready;
  logic [15:0] a0r = 0, a0i = 0, b0r = 0, b0i = 0, a1r = 0, a1i = 0, b1r = 0, b1i = 0;
  logic [3:0]  t0 = 0, t1 = 0, res_tag;
  logic        res_valid, res_id;
  logic [15:0] res_mr, res_mi;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  cmul_arbiter dut (
    .clock(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_ar(a0r), .req0_ai(a0i), .req0_br(b0r), .req0_bi(b0i),
    .req1_ar(a1r), .req1_ai(a1i), .req1_br(b1r), .req1_bi(b1i),
    .req0_tag(t0), .req1_tag(t1), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_tag(res_tag), .res_mr(res_mr), .res_mi(res_mi)
  );

`ifdef CMUL_ARB_ROUND_EN
  localparam logic [15:0] rnd_pos = 16'd1, rnd_neg = 16'd0;
  localparam longint      rnd_add = 16384;
`else
  localparam logic [15:0] rnd_pos = 16'd0, rnd_neg = 16'hFFFF;
  localparam longint      rnd_add = 0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cm(input logic signed [15:0] ar, ai, br, bi);
    longint rr, ri, ir, ii;
    rr = (longint'(ar) * longint'(br) + rnd_add) >>> 15;
    ri = (longint'(ar) * longint'(bi) + rnd_add) >>> 15;
    ir = (longint'(ai) * longint'(br) + rnd_add) >>> 15;
    ii = (longint'(ai) * longint'(bi) + rnd_add) >>> 15;
    return {16'(rr - ii), 16'(ri + ir)};
  endfunction

  typedef struct {logic id; logic [3:0] tag; logic [15:0] mr, mi;} item_t;
  item_t q[$];
  bit    m_last = 1, acc_last = 0, armed = 0;

  // Model: items in flight in acceptance order; an item is visible once it has sat one full cycle.
  always @(negedge clk) begin : cmp
    logic        exp_rv, gg;
    logic [1:0]  er;
    logic [31:0] p;
    item_t       it;
    gg     = &req_valid ? !m_last : req_valid[1];
    er     = (rst_n && req_valid != 0 && (q.size() < 2 || res_ready)) ? (gg ? 2'b10 : 2'b01) : 2'b00;
    exp_rv = q.size() == 2 || (q.size() == 1 && !acc_last);
    if (armed) begin
      chk("m_req_ready", req_ready, er);
      chk("m_res_valid", res_valid, exp_rv);
      if (exp_rv) begin
        chk("m_res_id", res_id, q[0].id);
        chk("m_res_tag", res_tag, q[0].tag);
        chk("m_res_mr", res_mr, q[0].mr);
        chk("m_res_mi", res_mi, q[0].mi);
      end
    end
    if (!rst_n) begin
      q.delete();
      m_last   = 1;
      acc_last = 0;
      armed    = 1;
    end else begin
      if (exp_rv && res_ready) void'(q.pop_front());
      if (er != 0) begin
        p      = gg ? cm(a1r, a1i, b1r, b1i) : cm(a0r, a0i, b0r, b0i);
        it.id  = gg;
        it.tag = gg ? t1 : t0;
        it.mr  = p[31:16];
        it.mi  = p[15:0];
        q.push_back(it);
        m_last = gg;
      end
      acc_last = er != 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit id, input logic [15:0] ar, ai, br, bi, input logic [3:0] tg);
    cyc();
    if (id) begin
      a1r = ar; a1i = ai; b1r = br; b1i = bi; t1 = tg; req_valid = 2'b10;
    end else begin
      a0r = ar; a0i = ai; b0r = br; b0i = bi; t0 = tg; req_valid = 2'b01;
    end
    @(negedge clk);
    chk("send_ready", req_ready, id ? 2'b10 : 2'b01);
    cyc();
    req_valid = 0;
    @(negedge clk);
    chk("send_latency_early", res_valid, 0);
    cyc();
    @(negedge clk);
    chk("send_res_valid", res_valid, 1);
  endtask

  initial begin
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_mr", res_mr, 0);
    chk("rst_res_tag", res_tag, 0);
    cyc();
    rst_n = 1;

    send(0, 16'd16384, 16'd0, 16'd16384, 16'd0, 4'd3);
    chk("single_mr", res_mr, 16'd8192);
    chk("single_mi", res_mi, 16'd0);
    chk("single_id", res_id, 0);
    chk("single_tag", res_tag, 3);

    send(1, 16'd16384, 16'd16384, 16'd16384, -16'sd16384, 4'd9);
    chk("cross_mr", res_mr, 16'd16384);
    chk("cross_mi", res_mi, 16'd0);
    chk("cross_id", res_id, 1);

    cyc();
    a0r = 16'd100; b0r = 16'd20000; a1r = -16'sd300; b1r = 16'd12345; t0 = 1; t1 = 2;
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("contention_grant", req_ready, (i % 2) ? 2'b10 : 2'b01);
      cyc();
    end
    req_valid = 0;
    repeat (3) cyc();

    res_ready = 0;
    a0r = 16'd16384; a0i = 0; b0r = 16'd1024; b0i = 0; t0 = 5; req_valid = 2'b01;
    @(negedge clk);
    chk("bp_ready0", req_ready, 2'b01);
    cyc();
    b0r = 16'd2048; t0 = 6;
    @(negedge clk);
    chk("bp_ready1", req_ready, 2'b01);
    cyc();
    b0r = 16'd3072; t0 = 7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_stall_ready", req_ready, 0);
      chk("bp_stall_valid", res_valid, 1);
      chk("bp_stall_tag", res_tag, 5);
      chk("bp_stall_mr", res_mr, 16'd512);
      cyc();
    end
    res_ready = 1;
    @(negedge clk);
    chk("bp_release_ready", req_ready, 2'b01);
    chk("bp_out0_tag", res_tag, 5);
    cyc();
    req_valid = 0;
    @(negedge clk);
    chk("bp_out1_tag", res_tag, 6);
    chk("bp_out1_mr", res_mr, 16'd1024);
    cyc();
    @(negedge clk);
    chk("bp_out2_tag", res_tag, 7);
    chk("bp_out2_mr", res_mr, 16'd1536);
    cyc();
    @(negedge clk);
    chk("bp_drained", res_valid, 0);

    send(0, 16'd1, 16'd0, 16'd16384, 16'd0, 4'd4);
    chk("round_pos_mr", res_mr, rnd_pos);
    send(0, 16'hFFFF, 16'd0, 16'd1, 16'd0, 4'd4);
    chk("round_neg_mr", res_mr, rnd_neg);

    cyc();
    res_ready = 0;
    req_valid = 2'b11;
    cyc();
    cyc();
    rst_n = 0;
    @(negedge clk);
    chk("midrst_ready_now", req_ready, 0);
    cyc();
    @(negedge clk);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_res_mr", res_mr, 0);
    cyc();
    rst_n = 1;
    @(negedge clk);
    chk("midrst_first_grant", req_ready, 2'b01);
    res_ready = 1;

    for (int i = 0; i < 3000; i++) begin
      cyc();
      req_valid = 2'($urandom);
      {a0r, a0i} = $urandom; {b0r, b0i} = $urandom;
      {a1r, a1i} = $urandom; {b1r, b1i} = $urandom;
      t0 = 4'($urandom); t1 = 4'($urandom);
      res_ready = $urandom_range(0, 9) < 7;
      rst_n = $urandom_range(0, 199) != 0;
    end
    cyc();
    rst_n = 1;
    req_valid = 0;
    res_ready = 1;
    repeat (4) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
